// File: rtl/sad_trigger_sequencer.sv
// rtl/sad_trigger_sequencer.sv - SAD match to shaped trigger sequencer with holdoff and per-arming budget
//
// Purpose:
//   Converts the SAD block's raw 1-cycle match strobe into a shaped trigger_out
//   pulse. Drives the SAD active input, enforces a dead time after each pulse,
//   limits the number of triggers per arming, and counts accepted and dropped
//   matches. Single clock domain (clk_adc).
//
// Ports:
//   clk_adc           in   ADC sample clock
//   reset             in   asynchronous, active-high
//   cfg_enable        in   sequencer enable; low forces IDLE on the next edge
//   cfg_always_armed  in   arm without an armed_and_ready rising edge
//   cfg_max_triggers  in   triggers per arming, 0 = unlimited
//   cfg_holdoff       in   dead cycles after each pulse
//   cfg_pulse_width   in   trigger_out high cycles, 0 behaves as 1
//   armed_and_ready   in   capture armed level
//   sad_match         in   SAD raw match strobe
//   sad_active        out  SAD .active (high only while ARMED)
//   trigger_out       out  shaped trigger
//   busy              out  sequencer not in IDLE
//   trigger_count     out  accepted triggers since arming
//   missed_count      out  matches dropped in PULSE/HOLDOFF, saturating

module sad_trigger_sequencer #(
    parameter int pCOUNT_W   = 8,
    parameter int pHOLDOFF_W = 16,
    parameter int pPULSE_W   = 8
) (
    input  logic                  clk_adc,
    input  logic                  reset,
    input  logic                  cfg_enable,
    input  logic                  cfg_always_armed,
    input  logic [pCOUNT_W-1:0]   cfg_max_triggers,
    input  logic [pHOLDOFF_W-1:0] cfg_holdoff,
    input  logic [pPULSE_W-1:0]   cfg_pulse_width,
    input  logic                  armed_and_ready,
    input  logic                  sad_match,
    output logic                  sad_active,
    output logic                  trigger_out,
    output logic                  busy,
    output logic [pCOUNT_W-1:0]   trigger_count,
    output logic [pCOUNT_W-1:0]   missed_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_PULSE   = 3'd2,
        S_HOLDOFF = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_arm_q;
    logic [pPULSE_W-1:0]   r_pulse_cnt;
    logic [pHOLDOFF_W-1:0] r_hold_cnt;
    logic [pCOUNT_W-1:0]   r_trig_cnt;
    logic [pCOUNT_W-1:0]   r_miss_cnt;
    logic                  r_sad_active;
    logic                  r_trigger_out;
    logic                  r_busy;

    logic                  w_arm_rise;
    logic                  w_pulse_last;
    logic                  w_hold_last;
    logic                  w_budget_hit;
    logic                  w_sad_active;
    logic                  w_trigger_out;
    logic                  w_busy;
    logic                  w_arm_entry;
    logic [pPULSE_W-1:0]   w_pulse_load;

    assign w_arm_rise   = armed_and_ready & ~r_arm_q;
    assign w_pulse_last = (r_pulse_cnt == '0);
    assign w_hold_last  = (r_hold_cnt == '0);
    // trigger_count already includes the pulse in progress when this is evaluated
    assign w_budget_hit = (cfg_max_triggers != '0) && (r_trig_cnt == cfg_max_triggers);
    assign w_arm_entry  = (r_state == S_IDLE) && (w_next == S_ARMED);
    // Counters run down to zero, so a width of N loads N-1; width 0 loads 0 like width 1
    assign w_pulse_load = (cfg_pulse_width == '0) ? '0 : (cfg_pulse_width - pPULSE_W'(1));

    // State and registered outputs
    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sad_active  <= 1'b0;
            r_trigger_out <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_sad_active  <= w_sad_active;
            r_trigger_out <= w_trigger_out;
            r_busy        <= w_busy;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (!cfg_enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arm_rise || cfg_always_armed) begin
                        w_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sad_match) begin
                        w_next = S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (w_pulse_last) begin
                        if (w_budget_hit) begin
                            w_next = S_DONE;
                        end else if (cfg_holdoff == '0) begin
                            w_next = S_ARMED;
                        end else begin
                            w_next = S_HOLDOFF;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (w_hold_last) begin
                        w_next = S_ARMED;
                    end
                end
                S_DONE: begin
                    if (!armed_and_ready && !cfg_always_armed) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe (match in cycle N -> trigger_out in N+1).
    always_comb begin
        w_sad_active  = (w_next == S_ARMED);
        w_trigger_out = (w_next == S_PULSE);
        w_busy        = (w_next != S_IDLE);
    end

    // Datapath: arming edge detect, pulse/holdoff timers, event counters
    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            r_arm_q     <= 1'b0;
            r_pulse_cnt <= '0;
            r_hold_cnt  <= '0;
            r_trig_cnt  <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_arm_q <= armed_and_ready;

            if (w_arm_entry) begin
                r_trig_cnt <= '0;
                r_miss_cnt <= '0;
            end else if (cfg_enable && sad_match) begin
                if (r_state == S_ARMED && r_trig_cnt != '1) begin
                    r_trig_cnt <= r_trig_cnt + pCOUNT_W'(1);
                end
                if ((r_state == S_PULSE || r_state == S_HOLDOFF) && r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + pCOUNT_W'(1);
                end
            end

            if (w_next == S_PULSE && r_state != S_PULSE) begin
                r_pulse_cnt <= w_pulse_load;
            end else if (r_state == S_PULSE && !w_pulse_last) begin
                r_pulse_cnt <= r_pulse_cnt - pPULSE_W'(1);
            end

            // HOLDOFF is only entered with a non-zero cfg_holdoff, so the load cannot underflow
            if (w_next == S_HOLDOFF && r_state != S_HOLDOFF) begin
                r_hold_cnt <= cfg_holdoff - pHOLDOFF_W'(1);
            end else if (r_state == S_HOLDOFF && !w_hold_last) begin
                r_hold_cnt <= r_hold_cnt - pHOLDOFF_W'(1);
            end
        end
    end

    assign sad_active    = r_sad_active;
    assign trigger_out   = r_trigger_out;
    assign busy          = r_busy;
    assign trigger_count = r_trig_cnt;
    assign missed_count  = r_miss_cnt;

endmodule

// File: tb/tb_sad_trigger_sequencer.sv
// tb/tb_sad_trigger_sequencer.sv - self-checking bench for sad_trigger_sequencer
module tb_sad_trigger_sequencer;

    logic        clk_adc;
    logic        reset;
    logic        cfg_enable;
    logic        cfg_always_armed;
    logic [7:0]  cfg_max_triggers;
    logic [15:0] cfg_holdoff;
    logic [7:0]  cfg_pulse_width;
    logic        armed_and_ready;
    logic        sad_match;
    logic        sad_active;
    logic        trigger_out;
    logic        busy;
    logic [7:0]  trigger_count;
    logic [7:0]  missed_count;

    int n_checks = 0;
    int n_errors = 0;

    sad_trigger_sequencer #(
        .pCOUNT_W   (8),
        .pHOLDOFF_W (16),
        .pPULSE_W   (8)
    ) dut (
        .clk_adc          (clk_adc),
        .reset            (reset),
        .cfg_enable       (cfg_enable),
        .cfg_always_armed (cfg_always_armed),
        .cfg_max_triggers (cfg_max_triggers),
        .cfg_holdoff      (cfg_holdoff),
        .cfg_pulse_width  (cfg_pulse_width),
        .armed_and_ready  (armed_and_ready),
        .sad_match        (sad_match),
        .sad_active       (sad_active),
        .trigger_out      (trigger_out),
        .busy             (busy),
        .trigger_count    (trigger_count),
        .missed_count     (missed_count)
    );

    initial clk_adc = 1'b0;
    always #5 clk_adc = ~clk_adc;

    typedef struct packed {
        logic        en;
        logic        aa;
        logic [7:0]  max;
        logic [15:0] hold;
        logic [7:0]  width;
        logic        rdy;
        logic        match;
        logic        e_act;
        logic        e_trig;
        logic        e_busy;
        logic [7:0]  e_tcnt;
        logic [7:0]  e_mcnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input int en, input int aa, input int max, input int hold, input int width,
                       input int rdy, input int match,
                       input int act, input int trig, input int bsy, input int tc, input int mc);
        vec_t v;
        v.en = 1'(en);       v.aa = 1'(aa);
        v.max = 8'(max);     v.hold = 16'(hold);  v.width = 8'(width);
        v.rdy = 1'(rdy);     v.match = 1'(match);
        v.e_act = 1'(act);   v.e_trig = 1'(trig); v.e_busy = 1'(bsy);
        v.e_tcnt = 8'(tc);   v.e_mcnt = 8'(mc);
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic apply(input vec_t v, input bit do_chk, input string tag, input int idx);
        vec_t e;
        cfg_enable       = v.en;
        cfg_always_armed = v.aa;
        cfg_max_triggers = v.max;
        cfg_holdoff      = v.hold;
        cfg_pulse_width  = v.width;
        armed_and_ready  = v.rdy;
        sad_match        = v.match;
        sb.push_back(v);
        @(posedge clk_adc);
        #1;
        e = sb.pop_front();
        if (do_chk) begin
            chk({tag, ".sad_active"},    idx, int'(sad_active),    int'(e.e_act));
            chk({tag, ".trigger_out"},   idx, int'(trigger_out),   int'(e.e_trig));
            chk({tag, ".busy"},          idx, int'(busy),          int'(e.e_busy));
            chk({tag, ".trigger_count"}, idx, int'(trigger_count), int'(e.e_tcnt));
            chk({tag, ".missed_count"},  idx, int'(missed_count),  int'(e.e_mcnt));
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1, tag, i);
        end
        tbl.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".sad_active"},    0, int'(sad_active),    0);
        chk({tag, ".trigger_out"},   0, int'(trigger_out),   0);
        chk({tag, ".busy"},          0, int'(busy),          0);
        chk({tag, ".trigger_count"}, 0, int'(trigger_count), 0);
        chk({tag, ".missed_count"},  0, int'(missed_count),  0);
    endtask

    initial begin
        vec_t v;
        reset            = 1'b1;
        cfg_enable       = 1'b0;
        cfg_always_armed = 1'b0;
        cfg_max_triggers = '0;
        cfg_holdoff      = '0;
        cfg_pulse_width  = '0;
        armed_and_ready  = 1'b0;
        sad_match        = 1'b0;
        repeat (2) @(posedge clk_adc);
        #1;
        check_zero("reset");
        reset = 1'b0;

        //    en aa max hold wid rdy m   act trg bsy tc mc
        // budget of 1, width 3, no holdoff
        add(1, 0, 1, 0,  3,  1,  0,  1,  0,  1,  0, 0);
        add(1, 0, 1, 0,  3,  1,  0,  1,  0,  1,  0, 0);
        add(1, 0, 1, 0,  3,  0,  0,  1,  0,  1,  0, 0);
        add(1, 0, 1, 0,  3,  1,  1,  0,  1,  1,  1, 0);
        add(1, 0, 1, 0,  3,  1,  0,  0,  1,  1,  1, 0);
        add(1, 0, 1, 0,  3,  1,  0,  0,  1,  1,  1, 0);
        add(1, 0, 1, 0,  3,  1,  0,  0,  0,  1,  1, 0);
        add(1, 0, 1, 0,  3,  1,  1,  0,  0,  1,  1, 0);
        add(1, 0, 1, 0,  3,  0,  0,  0,  0,  0,  1, 0);
        // unlimited, holdoff 5, width 1: matches at relative cycles 0, 3, 7
        add(1, 0, 0, 5,  1,  1,  0,  1,  0,  1,  0, 0);
        add(1, 0, 0, 5,  1,  1,  1,  0,  1,  1,  1, 0);
        add(1, 0, 0, 5,  1,  1,  0,  0,  0,  1,  1, 0);
        add(1, 0, 0, 5,  1,  1,  0,  0,  0,  1,  1, 0);
        add(1, 0, 0, 5,  1,  1,  1,  0,  0,  1,  1, 1);
        add(1, 0, 0, 5,  1,  1,  0,  0,  0,  1,  1, 1);
        add(1, 0, 0, 5,  1,  1,  0,  0,  0,  1,  1, 1);
        add(1, 0, 0, 5,  1,  1,  0,  1,  0,  1,  1, 1);
        add(1, 0, 0, 5,  1,  1,  1,  0,  1,  1,  2, 1);
        add(1, 0, 0, 5,  1,  1,  0,  0,  0,  1,  2, 1);
        // disable mid-holdoff, then width 0 gives a single-cycle pulse
        add(0, 0, 0, 5,  1,  1,  0,  0,  0,  0,  2, 1);
        add(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,  2, 1);
        add(1, 0, 0, 0,  0,  1,  0,  1,  0,  1,  0, 0);
        add(1, 0, 0, 0,  0,  1,  1,  0,  1,  1,  1, 0);
        add(1, 0, 0, 0,  0,  1,  0,  1,  0,  1,  1, 0);
        add(1, 0, 0, 0,  0,  1,  0,  1,  0,  1,  1, 0);
        run_table("tblA");

        // missed_count saturation across a long holdoff
        v = '0;
        v.en = 1'b1; v.hold = 16'd1000; v.width = 8'd1; v.rdy = 1'b1; v.match = 1'b1;
        v.e_trig = 1'b1; v.e_busy = 1'b1; v.e_tcnt = 8'd2;
        apply(v, 1'b1, "sat_entry", 0);
        v.e_trig = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            v.e_mcnt = (i > 255) ? 8'd255 : 8'(i);
            apply(v, (i == 254 || i == 255 || i == 256 || i == 300), "sat", i);
        end

        // asynchronous reset in the middle of HOLDOFF
        sad_match = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk_adc);
        #1;
        armed_and_ready = 1'b0;
        reset = 1'b0;

        //    en aa max hold wid rdy m   act trg bsy tc mc
        // enable drop on the 4th cycle of a width-10 pulse
        add(1, 0, 0, 0, 10,  1,  0,  1,  0,  1,  0, 0);
        add(1, 0, 0, 0, 10,  1,  1,  0,  1,  1,  1, 0);
        add(1, 0, 0, 0, 10,  1,  0,  0,  1,  1,  1, 0);
        add(1, 0, 0, 0, 10,  1,  0,  0,  1,  1,  1, 0);
        add(1, 0, 0, 0, 10,  1,  0,  0,  1,  1,  1, 0);
        add(0, 0, 0, 0, 10,  1,  1,  0,  0,  0,  1, 0);
        // always-armed with a budget of 2
        add(0, 1, 2, 0,  1,  0,  0,  0,  0,  0,  1, 0);
        add(1, 1, 2, 0,  1,  0,  0,  1,  0,  1,  0, 0);
        add(1, 1, 2, 0,  1,  0,  1,  0,  1,  1,  1, 0);
        add(1, 1, 2, 0,  1,  0,  0,  1,  0,  1,  1, 0);
        add(1, 1, 2, 0,  1,  0,  1,  0,  1,  1,  2, 0);
        add(1, 1, 2, 0,  1,  0,  0,  0,  0,  1,  2, 0);
        add(1, 1, 2, 0,  1,  0,  1,  0,  0,  1,  2, 0);
        add(1, 1, 2, 0,  1,  0,  0,  0,  0,  1,  2, 0);
        add(0, 1, 2, 0,  1,  0,  0,  0,  0,  0,  2, 0);
        add(1, 1, 2, 0,  1,  0,  0,  1,  0,  1,  0, 0);
        run_table("tblB");

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
